// File: rtl/seven_seg_scan_driver_if.sv
// seven_seg_scan_driver_if: display-side bundle between the BCD source and the scan driver
//   enable, bcd_data, dp_in, blink_mask, lz_blank : master -> slave (digit content and controls)
//   seg, dp, an, frame_tick                       : slave -> master (pin-level display outputs)
interface seven_seg_scan_driver_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    enable;
   logic [4*NUM_DIGITS-1:0] bcd_data;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blink_mask;
   logic                    lz_blank;
   logic [6:0]              seg;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   an;
   logic                    frame_tick;
   modport master (output enable, bcd_data, dp_in, blink_mask, lz_blank, input seg, dp, an, frame_tick);
   modport slave  (input enable, bcd_data, dp_in, blink_mask, lz_blank, output seg, dp, an, frame_tick);
endinterface

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed BCD-to-seven-segment scan driver
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   io    : slave side of seven_seg_scan_driver_if (inputs enable/bcd_data/dp_in/blink_mask/lz_blank,
//           outputs seg {g..a}, dp, an one-hot, frame_tick)
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 1000,
   parameter int BLINK_DIV      = 256,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input logic                    clk,
   input logic                    reset,
   seven_seg_scan_driver_if.slave io
);
   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int FW = $clog2(BLINK_DIV + 1);
   localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [FW-1:0] F_LAST = FW'(BLINK_DIV - 1);
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
   };
   logic [PW-1:0]           presc_q, presc_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [FW-1:0]           frame_q, frame_d;
   logic                    blink_q, blink_d;
   logic                    first_q, first_d;
   logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d, bcd_e;
   logic [NUM_DIGITS-1:0]   dps_q, dps_d, dps_e;
   logic [NUM_DIGITS-1:0]   mask_q, mask_d, mask_e;
   logic                    lz_q, lz_d, lz_e;
   logic [6:0]              seg_q, seg_d;
   logic                    dpo_q, dpo_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    tick_q, tick_d;
   logic                    last_slot, wrap, load, zeros, blank, dp_b, mask_b;
   logic [3:0]              digit;
   // Internal registers are active-high; pin polarity is a constant inversion of a flop output.
   assign io.seg        = seg_q ^ {7{SEG_ACTIVE_LOW}};
   assign io.dp         = dpo_q ^ SEG_ACTIVE_LOW;
   assign io.an         = an_q ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
   assign io.frame_tick = tick_q;
   always_comb begin
      last_slot = presc_q == P_LAST;
      wrap      = io.enable && last_slot && idx_q == I_LAST;
      load      = io.enable && (first_q || wrap);
      presc_d   = io.enable ? (last_slot ? '0 : presc_q + 1'b1) : presc_q;
      idx_d     = (io.enable && last_slot) ? (idx_q == I_LAST ? '0 : idx_q + 1'b1) : idx_q;
      frame_d   = wrap ? (frame_q == F_LAST ? '0 : frame_q + 1'b1) : frame_q;
      blink_d   = blink_q ^ (wrap && frame_q == F_LAST);
      first_d   = first_q && !io.enable;
      bcd_d     = load ? io.bcd_data : bcd_q;
      dps_d     = load ? io.dp_in : dps_q;
      mask_d    = load ? io.blink_mask : mask_q;
      lz_d      = load ? io.lz_blank : lz_q;
      // The very first enabled cycle displays the data it is capturing, so seg is valid in the dead slot.
      bcd_e     = first_q ? io.bcd_data : bcd_q;
      dps_e     = first_q ? io.dp_in : dps_q;
      mask_e    = first_q ? io.blink_mask : mask_q;
      lz_e      = first_q ? io.lz_blank : lz_q;
      digit     = '0;
      dp_b      = 1'b0;
      mask_b    = 1'b0;
      zeros     = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (IW'(i) == idx_q) begin
            digit  = bcd_e[4*i +: 4];
            dp_b   = dps_e[i];
            mask_b = mask_e[i];
         end
         // zeros ends up true when the current digit and every more significant one are 0
         if (IW'(i) >= idx_q && bcd_e[4*i +: 4] != 4'd0) zeros = 1'b0;
      end
      blank  = (lz_e && idx_q != '0 && zeros) || (blink_q && mask_b);
      an_d   = (io.enable && !blank && presc_q != '0) ? NUM_DIGITS'(1) << idx_q : '0;
      seg_d  = (io.enable && !blank) ? SEG_LUT[digit] : '0;
      dpo_d  = io.enable && !blank && dp_b;
      tick_d = wrap;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         presc_q <= '0;
         idx_q   <= '0;
         frame_q <= '0;
         blink_q <= 1'b0;
         first_q <= 1'b1;
         bcd_q   <= '0;
         dps_q   <= '0;
         mask_q  <= '0;
         lz_q    <= 1'b0;
         seg_q   <= '0;
         dpo_q   <= 1'b0;
         an_q    <= '0;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         blink_q <= blink_d;
         first_q <= first_d;
         bcd_q   <= bcd_d;
         dps_q   <= dps_d;
         mask_q  <= mask_d;
         lz_q    <= lz_d;
         seg_q   <= seg_d;
         dpo_q   <= dpo_d;
         an_q    <= an_d;
         tick_q  <= tick_d;
      end
endmodule
